lpddr5_refresh_ctrl: RTL and testbench

//   Refresh engine of the LPDDR5 controller. It sits between the interval timer and the command scheduler.
//   - Counts tREFI intervals and tracks owed refreshes.
//   - Requests a quiet bus, closes open banks with PREA, then issues all-bank REF.
//   - Blocks the scheduler for tRFC after each REF.

---
 rtl/lpddr5_refresh_ctrl_if.sv | 35 +++
 rtl/lpddr5_refresh_ctrl.sv | 145 ++++++++++++++
 tb/tb_lpddr5_refresh_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lpddr5_refresh_ctrl_if.sv
// Refresh engine <-> scheduler / interval-timer signal bundle for lpddr5_refresh_ctrl.
// master = refresh engine, slave = scheduler side.
interface lpddr5_refresh_ctrl_if #(
  parameter int unsigned BANK_NUM     = 8,
  parameter int unsigned MAX_POSTPONE = 8
);
  localparam int unsigned PEND_W = $clog2(MAX_POSTPONE + 1);

  logic                enable;
  logic                sched_idle;
  logic [BANK_NUM-1:0] bank_open;
  logic                ref_req;
  logic                ref_grant;
  logic                pre_all_valid;
  logic                pre_all_ready;
  logic                ref_valid;
  logic                ref_ready;
  logic                refresh_busy;
  logic                ref_done;
  logic [PEND_W-1:0]   pending_cnt;
  logic                urgent;
  logic                overflow;

  modport master (
    input  enable, sched_idle, bank_open, ref_grant, pre_all_ready, ref_ready,
    output ref_req, pre_all_valid, ref_valid, refresh_busy, ref_done,
           pending_cnt, urgent, overflow
  );

  modport slave (
    output enable, sched_idle, bank_open, ref_grant, pre_all_ready, ref_ready,
    input  ref_req, pre_all_valid, ref_valid, refresh_busy, ref_done,
           pending_cnt, urgent, overflow
  );
endinterface

// File: rtl/lpddr5_refresh_ctrl.sv
// LPDDR5 refresh engine: tREFI interval tracking, PREA/REF sequencing and tRFC blocking.
// Define LPDDR5_REF_POSTPONE_EN to allow up to MAX_POSTPONE owed refreshes deferred while traffic flows.
module lpddr5_refresh_ctrl #(
  parameter int unsigned BANK_NUM     = 8,
  parameter int unsigned T_RP         = 4,
  parameter int unsigned T_RFC        = 20,
  parameter int unsigned T_REFI       = 100,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lpddr5_refresh_ctrl_if.master bus
);
  localparam int unsigned PEND_W  = $clog2(MAX_POSTPONE + 1);
  localparam int unsigned REFI_W  = $clog2(T_REFI + 1);
  localparam int unsigned TMR_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
`ifdef LPDDR5_REF_POSTPONE_EN
  localparam int unsigned CAP     = MAX_POSTPONE;
`else
  localparam int unsigned CAP     = 1;
`endif
  localparam logic [BANK_NUM-1:0] ALL_CLOSED = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_PREA, S_WAIT_RP, S_REF, S_WAIT_RFC
  } state_t;

  state_t            state_q, state_d;
  logic [REFI_W-1:0] refi_q, refi_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              urgent_q, urgent_d;
  logic              ovf_q, ovf_d;
  logic              req_q, req_d;
  logic              pv_q, pv_d;
  logic              rv_q, rv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick_c, ref_hs_c, pre_hs_c, req_cond_c;

`ifdef LPDDR5_REF_POSTPONE_EN
  assign req_cond_c = bus.sched_idle | urgent_q;
`else
  logic unused_sched_idle;
  assign unused_sched_idle = bus.sched_idle;
  assign req_cond_c        = 1'b1;
`endif

  // Next-state, counters and registered-output values
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    refi_d   = refi_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    tick_c   = bus.enable && (refi_q == REFI_W'(T_REFI - 1));
    ref_hs_c = rv_q && bus.ref_ready;
    pre_hs_c = pv_q && bus.pre_all_ready;

    if (bus.enable) refi_d = tick_c ? '0 : refi_q + REFI_W'(1);

    // Simultaneous tick and REF handshake cancel out
    if (tick_c && !ref_hs_c) begin
      if (pend_q != PEND_W'(CAP)) pend_d = pend_q + PEND_W'(1);
    end else if (ref_hs_c && !tick_c) begin
      pend_d = pend_q - PEND_W'(1);
    end
    if (tick_c && (pend_q == PEND_W'(CAP))) ovf_d = 1'b1;
    urgent_d = (pend_d == PEND_W'(CAP));

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && (pend_q != '0) && req_cond_c) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.ref_grant) state_d = (bus.bank_open == ALL_CLOSED) ? S_REF : S_PREA;
      end
      S_PREA: begin
        if (pre_hs_c) begin
          state_d = S_WAIT_RP;
          tmr_d   = TMR_W'(T_RP - 1);
        end
      end
      S_WAIT_RP: begin
        if (tmr_q == '0) state_d = S_REF;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      S_REF: begin
        if (ref_hs_c) begin
          state_d = S_WAIT_RFC;
          tmr_d   = TMR_W'(T_RFC - 1);
        end
      end
      S_WAIT_RFC: begin
        if (tmr_q == '0) state_d = (pend_q != '0) ? S_REQ : S_IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    req_d  = (state_d != S_IDLE);
    pv_d   = (state_d == S_PREA);
    rv_d   = (state_d == S_REF);
    busy_d = (state_d == S_WAIT_RFC);
    done_d = busy_d && (tmr_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      refi_q   <= '0;
      pend_q   <= '0;
      urgent_q <= 1'b0;
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
      pv_q     <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      refi_q   <= refi_d;
      pend_q   <= pend_d;
      urgent_q <= urgent_d;
      ovf_q    <= ovf_d;
      req_q    <= req_d;
      pv_q     <= pv_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.ref_req       = req_q;
  assign bus.pre_all_valid = pv_q;
  assign bus.ref_valid     = rv_q;
  assign bus.refresh_busy  = busy_q;
  assign bus.ref_done      = done_q;
  assign bus.pending_cnt   = pend_q;
  assign bus.urgent        = urgent_q;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_lpddr5_refresh_ctrl.sv
// Scoreboard bench for lpddr5_refresh_ctrl: an event-level model predicts every cycle's outputs,
// a negedge monitor pops and compares them and checks handshake/timing properties.
`timescale 1ns/1ps
module tb_lpddr5_refresh_ctrl;
  localparam int unsigned BANK_NUM     = 8;
  localparam int unsigned T_RP         = 4;
  localparam int unsigned T_RFC        = 20;
  localparam int unsigned T_REFI       = 100;
  localparam int unsigned MAX_POSTPONE = 8;
  localparam int unsigned PEND_W       = $clog2(MAX_POSTPONE + 1);
`ifdef LPDDR5_REF_POSTPONE_EN
  localparam int CAP      = MAX_POSTPONE;
  localparam bit POSTPONE = 1'b1;
`else
  localparam int CAP      = 1;
  localparam bit POSTPONE = 1'b0;
`endif

  typedef struct packed {
    logic              req;
    logic              pv;
    logic              rv;
    logic              busy;
    logic              done;
    logic [PEND_W-1:0] pend;
    logic              urg;
    logic              ovf;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic en, idle, grant, pready, rready;
  logic [BANK_NUM-1:0] bo;

  always #5 clk = ~clk;

  lpddr5_refresh_ctrl_if #(.BANK_NUM(BANK_NUM), .MAX_POSTPONE(MAX_POSTPONE)) bus ();

  lpddr5_refresh_ctrl #(
    .BANK_NUM(BANK_NUM), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI), .MAX_POSTPONE(MAX_POSTPONE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  assign bus.enable        = en;
  assign bus.sched_idle    = idle;
  assign bus.bank_open     = bo;
  assign bus.ref_grant     = grant;
  assign bus.pre_all_ready = pready;
  assign bus.ref_ready     = rready;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  obs_t exp_q[$];

  // Reference model: interval arithmetic plus a named-stage sequence with remaining-cycle counts
  int    refi, pend, remain, done_exp;
  bit    ovf;
  string stage = "idle";
  obs_t  m;

  always @(posedge clk) begin
    int  old_pend;
    bit  old_urg, tick, rhs, phs;
    cyc = cyc + 1;
    if (rst) begin
      refi = 0; pend = 0; ovf = 1'b0; stage = "idle"; remain = 0; m = '0;
    end else begin
      old_pend = pend;
      old_urg  = m.urg;
      tick     = en && (refi == T_REFI - 1);
      rhs      = m.rv && rready;
      phs      = m.pv && pready;
      if (en) refi = tick ? 0 : refi + 1;
      if (tick && pend == CAP) ovf = 1'b1;
      if (tick && !rhs)      pend = (pend < CAP) ? pend + 1 : pend;
      else if (rhs && !tick) pend = pend - 1;

      if (stage == "idle") begin
        if (en && old_pend > 0 && (!POSTPONE || idle || old_urg)) stage = "req";
      end else if (stage == "req") begin
        if (grant) stage = (bo == '0) ? "ref" : "prea";
      end else if (stage == "prea") begin
        if (phs) begin stage = "rp"; remain = T_RP; end
      end else if (stage == "rp") begin
        remain = remain - 1;
        if (remain == 0) stage = "ref";
      end else if (stage == "ref") begin
        if (rhs) begin stage = "rfc"; remain = T_RFC; end
      end else if (stage == "rfc") begin
        remain = remain - 1;
        if (remain == 0) stage = (old_pend > 0) ? "req" : "idle";
      end

      m.req  = (stage != "idle");
      m.pv   = (stage == "prea");
      m.rv   = (stage == "ref");
      m.busy = (stage == "rfc");
      m.done = (stage == "rfc") && (remain == 1);
      m.pend = PEND_W'(pend);
      m.urg  = (pend == CAP);
      m.ovf  = ovf;
      if (m.done) done_exp = done_exp + 1;
    end
    exp_q.push_back(m);
  end

  // Monitor: per-cycle scoreboard compare plus protocol/timing observations
  int   arm_id = 0, arm_cyc = 0, seen_id = 0;
  int   hs_cyc = -1, busy_run = 0, done_seen = 0;
  logic prev_pv = 1'b0, prev_rv = 1'b0, prev_req = 1'b0;
  bit   prev_phs = 1'b0, prev_rhs = 1'b0;

  always @(negedge clk) begin
    obs_t got, want;
    got = {bus.ref_req, bus.pre_all_valid, bus.ref_valid, bus.refresh_busy, bus.ref_done,
           bus.pending_cnt, bus.urgent, bus.overflow};
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      if (rst) want = '0;
      checks = checks + 1;
      if (got !== want) begin
        errors = errors + 1;
        $display("FAIL outputs cyc=%0d got req/pv/rv/busy/done=%b%b%b%b%b pend=%0d urg=%b ovf=%b want %b%b%b%b%b pend=%0d urg=%b ovf=%b",
                 cyc, got.req, got.pv, got.rv, got.busy, got.done, got.pend, got.urg, got.ovf,
                 want.req, want.pv, want.rv, want.busy, want.done, want.pend, want.urg, want.ovf);
      end
    end
    if (rst) begin
      hs_cyc = -1; busy_run = 0;
      prev_pv = 1'b0; prev_rv = 1'b0; prev_req = 1'b0; prev_phs = 1'b0; prev_rhs = 1'b0;
    end else begin
      if (prev_pv && !prev_phs) begin
        checks = checks + 1;
        if (got.pv !== 1'b1) begin errors = errors + 1; $display("FAIL pv_hold cyc=%0d got %b want 1", cyc, got.pv); end
      end
      if (prev_rv && !prev_rhs) begin
        checks = checks + 1;
        if (got.rv !== 1'b1) begin errors = errors + 1; $display("FAIL rv_hold cyc=%0d got %b want 1", cyc, got.rv); end
      end
      if (got.rv && !prev_rv && hs_cyc >= 0) begin
        checks = checks + 1;
        if (cyc - hs_cyc != T_RP + 1) begin
          errors = errors + 1;
          $display("FAIL prea_to_ref gap got %0d want %0d", cyc - hs_cyc, T_RP + 1);
        end
        hs_cyc = -1;
      end
      if (got.pv && pready) hs_cyc = cyc;
      if (got.busy) busy_run = busy_run + 1;
      else if (busy_run != 0) begin
        checks = checks + 1;
        if (busy_run != T_RFC) begin
          errors = errors + 1;
          $display("FAIL busy_len got %0d want %0d", busy_run, T_RFC);
        end
        busy_run = 0;
      end
      if (got.req && !prev_req && arm_id != seen_id) begin
        checks = checks + 1;
        if (cyc - arm_cyc != T_REFI + 1) begin
          errors = errors + 1;
          $display("FAIL first_req_latency got %0d want %0d", cyc - arm_cyc, T_REFI + 1);
        end
        seen_id = arm_id;
      end
      if (got.done) done_seen = done_seen + 1;
      prev_pv  = got.pv;
      prev_rv  = got.rv;
      prev_req = got.req;
      prev_phs = got.pv && pready;
      prev_rhs = got.rv && rready;
    end
  end

  task automatic drive(input bit e, input bit i, input logic [BANK_NUM-1:0] b,
                       input bit g, input bit p, input bit r);
    @(posedge clk);
    #1;
    en = e; idle = i; bo = b; grant = g; pready = p; rready = r;
  endtask

  task automatic timeout_check(input bit met, input string what);
    checks = checks + 1;
    if (!met) begin
      errors = errors + 1;
      $display("FAIL wait_%s got timeout want event", what);
    end
  endtask

  initial begin
    bit met;
    done_exp = 0;
    en = 0; idle = 0; bo = '0; grant = 0; pready = 0; rready = 0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) drive(0, 0, '0, 0, 0, 0);

    // Plain refresh: banks closed, everything granted
    drive(1, 1, '0, 1, 1, 1);
    arm_cyc = cyc; arm_id = arm_id + 1;
    repeat (250) drive(1, 1, '0, 1, 1, 1);

    // Open banks with PREA back-pressure held 10 cycles
    met = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (m.pv) begin met = 1'b1; break; end
      drive(1, 1, 8'h05, 1, 0, 1);
    end
    timeout_check(met, "prea");
    repeat (10) drive(1, 1, 8'h05, 1, 0, 1);
    repeat (150) drive(1, 1, 8'h05, 1, 1, 1);

    // Grant withheld across several ticks: pending saturates, overflow sticks
    repeat (900) drive(1, 0, '0, 0, 0, 0);
    repeat (60) drive(1, 1, '0, 1, 1, 1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? '0 : BANK_NUM'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    // Reset in the fifth cycle of the tRFC window
    met = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (stage == "rfc" && remain == T_RFC - 4) begin met = 1'b1; break; end
      drive(1, 1, '0, 1, 1, 1);
    end
    timeout_check(met, "rfc5");
    rst = 1'b1;
    repeat (2) drive(1, 1, '0, 1, 1, 1);
    rst = 1'b0;
    arm_cyc = cyc; arm_id = arm_id + 1;
    repeat (250) drive(1, 1, '0, 1, 1, 1);

    // Enable dropped mid-run, then more random traffic
    repeat (300) drive(0, 1, '0, 1, 1, 1);
    for (int k = 0; k < 1500; k++) begin
      drive(1, $urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? BANK_NUM'($urandom) : '0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);

    checks = checks + 1;
    if (done_seen != done_exp || done_exp == 0) begin
      errors = errors + 1;
      $display("FAIL ref_done_count got %0d want %0d (nonzero)", done_seen, done_exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
